trap_sequencer: RTL

Interrupt entry/exit controller for the M-mode CSR unit in the CPU pipeline. Samples the external and timer interrupt lines, gates them with the enables exported by the CSR, arbitrates between them, and parks the core on WFI. It then drives the CSR's trap-entry and trap-exit strobes, the pipeline flush and the WFI indicator, holding each strobe until the front end is not stalled. It handles one trap at a time: no nesting, no re-arbitration inside a handler.

---
 rtl/trap_sequencer_if.sv | 36 +++
 rtl/trap_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: interrupt lines, CSR enables, EX-stage events and trap strobes.
// master = pipeline/CSR side driving requests; slave = the sequencer driving strobes.
// Strobes are held by the sequencer while stall_IF is high; no other flow control.
interface trap_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             irq_ext;
  logic             irq_timer;
  logic             mie_in;
  logic             meie_in;
  logic             mtie_in;
  logic             wfi_valid;
  logic             mret_valid;
  logic             stall_IF;
  logic             intr_ex;
  logic             intr_t;
  logic             intr_end_ex;
  logic             intr_end_t;
  logic             flush;
  logic             wfi_signal;
  logic             in_trap;
  logic             cause;
  logic [CNT_W-1:0] handler_cycles;

  modport master (
    output irq_ext, irq_timer, mie_in, meie_in, mtie_in, wfi_valid, mret_valid, stall_IF,
    input  intr_ex, intr_t, intr_end_ex, intr_end_t, flush, wfi_signal, in_trap, cause,
           handler_cycles
  );

  modport slave (
    input  irq_ext, irq_timer, mie_in, meie_in, mtie_in, wfi_valid, mret_valid, stall_IF,
    output intr_ex, intr_t, intr_end_ex, intr_end_t, flush, wfi_signal, in_trap, cause,
           handler_cycles
  );
endinterface

// File: rtl/trap_sequencer.sv
// M-mode trap entry/exit sequencer: arbitrates ext/timer interrupts, parks on WFI, strobes the CSR.
// Latency: request sampled at edge N -> entry strobe from cycle N+1; MRET at edge M -> exit strobe at M+1.
// Backpressure: entry/exit strobes and flush are held for as long as stall_IF is high.
module trap_sequencer #(
  parameter int unsigned GAP   = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  trap_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WFI     = 3'd1,
    S_ENTER   = 3'd2,
    S_HANDLER = 3'd3,
    S_EXIT    = 3'd4
  } state_t;

  localparam logic [3:0] GAP_L = 4'(GAP);

  state_t           state_q;
  logic [3:0]       gap_q;
  logic             cause_q;
  logic [CNT_W-1:0] cycles_q;

  logic pend_ext;
  logic pend_t;
  logic pend_any;
  logic take;

  // Enabled request terms; external has priority when the cause is latched.
  assign pend_ext = bus.irq_ext & bus.meie_in;
  assign pend_t   = bus.irq_timer & bus.mtie_in;
  assign pend_any = pend_ext | pend_t;
  assign take     = bus.mie_in & pend_any & (gap_q == 4'd0);

  // Single state machine: state, cause latch, post-exit gap counter and handler cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gap_q    <= 4'd0;
      cause_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
          // A simultaneous WFI loses to the trap; MRET here is meaningless and dropped.
          if (take) begin
            state_q <= S_ENTER;
            cause_q <= pend_ext;
          end else if (bus.wfi_valid) begin
            state_q <= S_WFI;
          end
        end
        S_WFI: begin
          if (gap_q != 4'd0) gap_q <= gap_q - 4'd1;
          // A pending but globally masked interrupt wakes the core without trapping.
          if (take) begin
            state_q <= S_ENTER;
            cause_q <= pend_ext;
          end else if (pend_any & ~bus.mie_in) begin
            state_q <= S_IDLE;
          end
        end
        S_ENTER: begin
          // Entry is committed: a request dropping here does not cancel it.
          if (!bus.stall_IF) begin
            state_q  <= S_HANDLER;
            cycles_q <= '0;
          end
        end
        S_HANDLER: begin
          if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
          if (bus.mret_valid & ~bus.stall_IF) state_q <= S_EXIT;
        end
        S_EXIT: begin
          if (!bus.stall_IF) begin
            state_q <= S_IDLE;
            gap_q   <= GAP_L;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so reset clears them immediately.
  assign bus.intr_ex        = (state_q == S_ENTER) &  cause_q;
  assign bus.intr_t         = (state_q == S_ENTER) & ~cause_q;
  assign bus.intr_end_ex    = (state_q == S_EXIT)  &  cause_q;
  assign bus.intr_end_t     = (state_q == S_EXIT)  & ~cause_q;
  assign bus.flush          = (state_q == S_ENTER) | (state_q == S_EXIT);
  assign bus.wfi_signal     = (state_q == S_WFI);
  assign bus.in_trap        = (state_q == S_ENTER) | (state_q == S_HANDLER) | (state_q == S_EXIT);
  assign bus.cause          = cause_q;
  assign bus.handler_cycles = cycles_q;

endmodule
